// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch path. It holds the default frame
// start marker, the instruction word width and the state encoding of the
// program loader.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int         INSTR_WIDTH       = 32;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake and the instruction memory write port used
// by the program loader.
//   in_data / in_valid / in_ready : byte stream from the source to the loader
//   imem_we / imem_addr / imem_wdata : one-word write port into instruction memory
// Modports:
//   slave  - the loader: it consumes the stream and drives the memory port
//   master - the byte source/host side: it drives the stream and observes the port
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  import cpu_pkg::*;

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   imem_we;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a framed byte stream (SYNC_BYTE, 16-bit word count N MSB first, then
// N big-endian 32-bit words). It writes the words into instruction memory at
// consecutive word addresses starting at 0. The CPU core is held in reset until
// a load completes.
// Ports:
//   clk, rst      - system clock; synchronous active-high reset
//   bus (slave)   - byte stream handshake plus the imem write port
//   cpu_rst       - reset request to the CPU core
//   done          - one-cycle pulse when a frame has been fully loaded
//   error         - held high after a frame whose count exceeds memory size
//   words_loaded  - number of words written in the current or last frame
// -----------------------------------------------------------------------------
module imem_loader
  import cpu_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  imem_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // Memory depth as a 17-bit value so that a full 16-bit count can be compared
  // against it without overflow, even when ADDR_WIDTH is 16.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  loader_state_t state_reg, state_next;

  logic [15:0]            count_reg;
  logic [1:0]             byte_idx_reg;
  logic [23:0]            shift_reg;      // first three bytes of the word in flight
  logic [INSTR_WIDTH-1:0] wdata_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [15:0]            words_loaded_reg;
  logic                   loaded_reg;

  logic        in_ready_c;
  logic        imem_we_c;
  logic        cpu_rst_c;
  logic        done_c;
  logic        error_c;
  logic [16:0] frame_len;

  // The full count becomes known in the same cycle the low byte transfers.
  assign frame_len = {1'b0, count_reg[15:8], bus.in_data};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs. in_ready depends only on the state, so
  // each receive state tests in_valid directly. A transfer is therefore
  // in_valid in any state that drives in_ready high.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready_c = 1'b0;
    imem_we_c  = 1'b0;
    cpu_rst_c  = 1'b1;
    done_c     = 1'b0;
    error_c    = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        cpu_rst_c  = ~loaded_reg;
        if (bus.in_valid && (bus.in_data == SYNC_BYTE)) begin
          state_next = CNT_HI;
        end
      end

      CNT_HI: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = CNT_LO;
        end
      end

      CNT_LO: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (frame_len > DEPTH) begin
            state_next = ERR;
          end else if (frame_len == 17'd0) begin
            state_next = DONE;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && (byte_idx_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end

      WRITE: begin
        imem_we_c = 1'b1;
        if ((words_loaded_reg + 16'd1) == count_reg) begin
          state_next = DONE;
        end else begin
          state_next = DATA;
        end
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      ERR: begin
        error_c = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: count capture, byte-to-word shifter, write address/data and the
  // loaded flag. The address and data are latched when the fourth byte of a
  // word arrives. They then stay stable through WRITE and afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg        <= '0;
      byte_idx_reg     <= '0;
      shift_reg        <= '0;
      wdata_reg        <= '0;
      addr_reg         <= '0;
      words_loaded_reg <= '0;
      loaded_reg       <= 1'b0;
    end else begin
      case (state_reg)
        CNT_HI: begin
          if (bus.in_valid) begin
            count_reg[15:8] <= bus.in_data;
          end
        end

        CNT_LO: begin
          if (bus.in_valid) begin
            count_reg[7:0]   <= bus.in_data;
            words_loaded_reg <= '0;
            byte_idx_reg     <= '0;
          end
        end

        DATA: begin
          if (bus.in_valid) begin
            shift_reg    <= {shift_reg[15:0], bus.in_data};
            byte_idx_reg <= byte_idx_reg + 2'd1;   // wraps to 0 for the next word
            if (byte_idx_reg == 2'd3) begin
              wdata_reg <= {shift_reg, bus.in_data};
              addr_reg  <= words_loaded_reg[ADDR_WIDTH-1:0];
            end
          end
        end

        WRITE: begin
          words_loaded_reg <= words_loaded_reg + 16'd1;
        end

        DONE: begin
          loaded_reg <= 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.imem_we    = imem_we_c;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign cpu_rst        = cpu_rst_c;
  assign done           = done_c;
  assign error          = error_c;
  assign words_loaded   = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed testbench for imem_loader with ADDR_WIDTH=8 and SYNC_BYTE=8'hA5.
// The bench drives inputs on the falling edge and samples outputs there too.
// A monitor records every memory write seen on a rising edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(
    .ADDR_WIDTH(8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write log filled by the monitor
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt   = 0;
  int          ready_viol = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.imem_we) begin
        wa_q.push_back(bus.imem_addr);
        wd_q.push_back(bus.imem_wdata);
        $display("write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
        if (bus.in_ready) ready_viol++;
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [31:0] big_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 8'hC3, ~b, 8'h5A};
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt   = 0;
    ready_viol = 0;
  endtask

  // Ends on a falling edge with the DUT freshly out of reset
  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  // Starts and ends on a falling edge. While the byte is idle, in_data carries
  // a decoy sync value so that any sampling without in_valid shows up.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.in_ready) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%b required=1 byte=%h", bus.in_ready, b);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    $display("test_reset");
    total++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 1'b0, 8'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_bus: got rdy=%b we=%b addr=%h data=%h required 1 0 00 00000000",
               bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    total++;
    if ({cpu_rst, done, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset_ctl: got cpu_rst=%b done=%b error=%b wl=%0d required 1 0 0 0",
               cpu_rst, done, error, words_loaded);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    $display("test_nominal");
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h20080005, 1'b0);
    total++;
    if ({bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata} !== {1'b1, 1'b0, 8'd0, 32'h20080005}) begin
      bad++;
      $display("FAIL nom_write0: got we=%b rdy=%b addr=%h data=%h required 1 0 00 20080005",
               bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata);
    end
    send_word(32'h01095020, 1'b0);
    total++;
    if ({bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata} !== {1'b1, 1'b0, 8'd1, 32'h01095020}) begin
      bad++;
      $display("FAIL nom_write1: got we=%b rdy=%b addr=%h data=%h required 1 0 01 01095020",
               bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata);
    end
    @(negedge clk);
    total++;
    if ({done, cpu_rst, bus.in_ready, words_loaded} !== {1'b1, 1'b1, 1'b0, 16'd2}) begin
      bad++;
      $display("FAIL nom_done: got done=%b cpu_rst=%b rdy=%b wl=%0d required 1 1 0 2",
               done, cpu_rst, bus.in_ready, words_loaded);
    end
    @(negedge clk);
    total++;
    if ({done, cpu_rst, bus.in_ready, bus.imem_we} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL nom_release: got done=%b cpu_rst=%b rdy=%b we=%b required 0 0 1 0",
               done, cpu_rst, bus.in_ready, bus.imem_we);
    end
    total++;
    if ({bus.imem_addr, bus.imem_wdata} !== {8'd1, 32'h01095020}) begin
      bad++;
      $display("FAIL nom_hold: got addr=%h data=%h required 01 01095020", bus.imem_addr, bus.imem_wdata);
    end
    total++;
    if (wa_q.size() != 2) begin
      bad++;
      $display("FAIL nom_count: got %0d writes required 2", wa_q.size());
    end
  endtask

  task automatic test_n0(input bit noise);
    do_reset();
    $display("test_n0 noise=%0d", noise);
    if (noise) begin
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h13, 0);
      total++;
      if ({cpu_rst, bus.in_ready} !== 2'b11) begin
        bad++;
        $display("FAIL n0_noise: got cpu_rst=%b rdy=%b required 1 1", cpu_rst, bus.in_ready);
      end
    end
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++;
    if ({done, cpu_rst, bus.in_ready, words_loaded} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL n0_done: got done=%b cpu_rst=%b rdy=%b wl=%0d required 1 1 0 0",
               done, cpu_rst, bus.in_ready, words_loaded);
    end
    @(negedge clk);
    total++;
    if ({done, cpu_rst} !== 2'b00) begin
      bad++;
      $display("FAIL n0_release: got done=%b cpu_rst=%b required 0 0", done, cpu_rst);
    end
    total++;
    if (wa_q.size() != 0) begin
      bad++;
      $display("FAIL n0_writes: got %0d writes required 0", wa_q.size());
    end
  endtask

  task automatic test_overflow();
    int seen_ready;
    int errs;
    do_reset();
    $display("test_overflow N=257");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    total++;
    if ({error, bus.in_ready, cpu_rst} !== 3'b101) begin
      bad++;
      $display("FAIL ovf_err: got error=%b rdy=%b cpu_rst=%b required 1 0 1", error, bus.in_ready, cpu_rst);
    end
    seen_ready = 0;
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready) seen_ready++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (seen_ready != 0 || error !== 1'b1) begin
      bad++;
      $display("FAIL ovf_stuck: got ready_cycles=%0d error=%b required 0 1", seen_ready, error);
    end
    do_reset();
    total++;
    if ({error, bus.in_ready, cpu_rst} !== 3'b011) begin
      bad++;
      $display("FAIL ovf_clear: got error=%b rdy=%b cpu_rst=%b required 0 1 1", error, bus.in_ready, cpu_rst);
    end
    $display("test_overflow N=256");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) send_word(big_word(i), 1'b0);
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 8'd255, big_word(255)}) begin
      bad++;
      $display("FAIL full_last: got we=%b addr=%h data=%h required 1 ff %h",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, big_word(255));
    end
    @(negedge clk);
    total++;
    if ({done, error, words_loaded} !== {1'b1, 1'b0, 16'd256}) begin
      bad++;
      $display("FAIL full_done: got done=%b error=%b wl=%0d required 1 0 256", done, error, words_loaded);
    end
    errs = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== 8'(i) || wd_q[i] !== big_word(i)) errs++;
    end
    total++;
    if (wa_q.size() != 256 || errs != 0) begin
      bad++;
      $display("FAIL full_log: got writes=%0d wrong=%0d required 256 0", wa_q.size(), errs);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] exp_w[3];
    int n;
    exp_w[0] = 32'hDEADBEEF;
    exp_w[1] = 32'hA5A5A5A5;
    exp_w[2] = 32'h00000013;
    do_reset();
    $display("test_gaps");
    send_byte(8'hA5, 2);
    send_byte(8'h00, 1);
    send_byte(8'h03, 3);
    for (int i = 0; i < 3; i++) send_word(exp_w[i], 1'b1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL gap_done_timeout: got done=%b required 1", done);
    end
    total++;
    if (wa_q.size() != 3) begin
      bad++;
      $display("FAIL gap_count: got %0d writes required 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_w[i]) begin
          bad++;
          $display("FAIL gap_word%0d: got addr=%h data=%h required %h %h", i, wa_q[i], wd_q[i], 8'(i), exp_w[i]);
        end
      end
    end
    total++;
    if (ready_viol != 0 || words_loaded !== 16'd3) begin
      bad++;
      $display("FAIL gap_ready: got ready_in_write=%0d wl=%0d required 0 3", ready_viol, words_loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    $display("test_reset_mid");
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    total++;
    if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst, done, error, words_loaded} !==
        {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b wl=%0d required 1 0 00 00000000 1 0 0 0",
               bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst, done, error, words_loaded);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h12345678, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (wa_q.size() != 2 || wa_q[0] !== 8'd0 || wd_q[0] !== 32'hCAFEF00D ||
        wa_q[1] !== 8'd1 || wd_q[1] !== 32'h12345678) begin
      bad++;
      $display("FAIL mid_reload: got writes=%0d first=%h last=%h required 2 cafef00d 12345678",
               wa_q.size(), wd_q.size() > 0 ? wd_q[0] : 32'hx, wd_q.size() > 1 ? wd_q[1] : 32'hx);
    end
    total++;
    if (cpu_rst !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: got cpu_rst=%b required 0", cpu_rst);
    end
  endtask

  task automatic test_reload();
    int low_cnt;
    clear_log();
    $display("test_reload");
    total++;
    if (cpu_rst !== 1'b0) begin
      bad++;
      $display("FAIL reload_pre: got cpu_rst=%b required 0", cpu_rst);
    end
    send_byte(8'hA5, 0);
    total++;
    if (cpu_rst !== 1'b1) begin
      bad++;
      $display("FAIL reload_rise: got cpu_rst=%b required 1", cpu_rst);
    end
    low_cnt = 0;
    send_byte(8'h00, 0);
    if (!cpu_rst) low_cnt++;
    send_byte(8'h01, 1);
    if (!cpu_rst) low_cnt++;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i == 3 ? 8'h6F : 8'h00), 1);
      if (!cpu_rst) low_cnt++;
    end
    @(negedge clk);
    total++;
    if (low_cnt != 0 || {done, cpu_rst} !== 2'b11) begin
      bad++;
      $display("FAIL reload_hold: got low_cycles=%0d done=%b cpu_rst=%b required 0 1 1", low_cnt, done, cpu_rst);
    end
    @(negedge clk);
    total++;
    if (cpu_rst !== 1'b0 || wa_q.size() != 1 || wd_q[0] !== 32'h0000006F) begin
      bad++;
      $display("FAIL reload_end: got cpu_rst=%b writes=%0d required 0 1 (data 0000006f)", cpu_rst, wa_q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_n0(1'b1);
    test_n0(1'b0);
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
